instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch stage directly upstream of instr_memory: owns the PC, drives instr_memory's 8-bit word address and
//  captures the returned 32-bit instruction into a small prefetch queue. Feeds decode over a valid/ready handshake.
//  Supports branch/jump redirect with flush of all queued and in-flight fetches.
//  instr_memory read latency is fixed at 1 cycle: instruction for address A is valid on imem_instr the cycle after A.
// PARAMETERS
//  DEPTH     4      prefetch queue entries, power of 2, 2..16
//  RESET_PC  8'h00  PC value loaded on reset
// PORTS
//  clk          in   1   single clock, rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  fetch_en     in   1   1 = fetching allowed; 0 = stop issuing new fetches
//  imem_addr    out  8   word address to instr_memory (registered PC)
//  imem_instr   in   32  instr_memory read data, 1 cycle after imem_addr
//  redirect     in   1   1-cycle pulse: flush and restart at redirect_pc
//  redirect_pc  in   8   new fetch address, sampled when redirect=1
//  dec_valid    out  1   queue head holds a valid instruction
//  dec_ready    in   1   decode accepts head this cycle
//  dec_instr    out  32  queue head instruction
//  dec_pc       out  8   address the head instruction was fetched from
//  fetch_cnt    out  16  [FETCH_STATS_EN only] instructions delivered to decode
//  flush_cnt    out  16  [FETCH_STATS_EN only] redirects taken
// BEHAVIOUR
//  - Reset (async, rst_n=0): pc=RESET_PC, state=IDLE, count=0, inflight=0, queue pointers 0.
//    Outputs on reset: imem_addr=RESET_PC, dec_valid=0, dec_instr=0, dec_pc=0, stat counters=0.
//    Reset asserted mid-operation drops all queued and in-flight data immediately.
//  - FSM, 2 states:
//    IDLE -> RUN when fetch_en=1.
//    RUN -> IDLE when fetch_en=0.
//    redirect does not change state.
//  - Issue (RUN only): issue = (count + inflight < DEPTH) && !redirect.
//    On issue: inflight<=1, inflight_pc<=pc, pc<=pc+1 (8-bit, 8'hFF wraps to 8'h00).
//    No issue: inflight<=0, pc holds.
//  - Capture: if inflight=1 and redirect=0, push {imem_instr, inflight_pc} into the queue the cycle after issue.
//    An in-flight fetch still completes after a RUN->IDLE transition.
//  - Throughput: 1 instruction/cycle sustained when decode is always ready.
//  - Latency: first dec_valid is 2 cycles after entering RUN (issue cycle + capture cycle).
//  - Handshake: pop when dec_valid && dec_ready. dec_valid=(count!=0)&&!redirect.
//    dec_instr/dec_pc hold stable while dec_valid=1 and dec_ready=0.
//  - Full: credit check (count+inflight) means the queue never overflows; a push while full is impossible by design.
//    Push and pop in the same cycle leave count unchanged, including when count=DEPTH.
//  - Empty: dec_valid=0; dec_instr/dec_pc hold their last value (don't-care).
//  - Redirect (highest priority, any state): count<=0, inflight<=0, pc<=redirect_pc.
//    No issue, push or pop that cycle. Next RUN cycle issues redirect_pc.
//    First instruction from redirect_pc reaches dec_valid 2 cycles after the redirect cycle.
//  - rst_n has priority over redirect.
// CONFIGURATION
//  FETCH_STATS_EN defined:
//    fetch_cnt increments on each dec_valid&&dec_ready handshake.
//    flush_cnt increments on each redirect.
//    Both are 16-bit, wrap at 16'hFFFF->0, and reset to 0.
//  FETCH_STATS_EN undefined: both ports and their counters are absent. Core behaviour is identical.
// TESTING  (memory model: word A = 32'hA000_0000 + A, registered read)
//  1. Reset, fetch_en=1, dec_ready=1 -> dec_valid first high 2 cycles after fetch_en.
//     Then dec_pc=0,1,2,... and dec_instr=32'hA000_0000,+1,... one per cycle.
//  2. dec_ready=0 for 10 cycles, DEPTH=4 -> count saturates at 4 and imem_addr stops at 8'h04.
//     Head stays 32'hA000_0000. Release dec_ready -> 4 back-to-back pops, in order, no loss or duplication.
//  3. redirect=1 with redirect_pc=8'h40 while queue holds 3 entries:
//     next cycle dec_valid=0 and imem_addr=8'h40; dec_pc=8'h40 arrives 2 cycles after redirect.
//  4. redirect_pc=8'hFE, dec_ready=1 -> dec_pc sequence FE, FF, 00, 01 (wrap).
//  5. rst_n low for 1 cycle mid-stream with a full queue -> dec_valid=0 and imem_addr=RESET_PC immediately.
//     Resume at RESET_PC after rst_n returns high.
//  6. FETCH_STATS_EN: 20 handshakes and 2 redirects -> fetch_cnt=20, flush_cnt=2.
//     Build without the macro -> ports absent and scenarios 1-5 pass unchanged.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - instruction memory and decode handshake bundle for instr_fetch_unit
interface instr_fetch_unit_if;
    logic [7:0]  imem_addr;
    logic [31:0] imem_instr;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [7:0]  dec_pc;

    modport master (
        output imem_addr,
        input  imem_instr,
        output dec_valid,
        input  dec_ready,
        output dec_instr,
        output dec_pc
    );

    modport slave (
        input  imem_addr,
        output imem_instr,
        input  dec_valid,
        output dec_ready,
        input  dec_instr,
        input  dec_pc
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC owner, 1-cycle imem fetch, prefetch queue to decode; FETCH_STATS_EN adds counters
module instr_fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [7:0]  RESET_PC = 8'h00
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 fetch_en,
    input  logic                 redirect,
    input  logic [7:0]           redirect_pc,
    instr_fetch_unit_if.master   bus
`ifdef FETCH_STATS_EN
    ,
    output logic [15:0]          fetch_cnt,
    output logic [15:0]          flush_cnt
`endif
);
    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned CW  = AW + 1;
    localparam int unsigned CSW = CW + 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_q;
    logic [7:0]      pc_q;
    logic            inflight_q;
    logic [7:0]      inflight_pc_q;
    logic [CW-1:0]   count_q;
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [31:0]     instr_mem_q [DEPTH];
    logic [7:0]      pc_mem_q    [DEPTH];

    logic [CSW-1:0]  credit;
    logic            issue;
    logic            push;
    logic            pop;
    logic            dec_valid_w;
    logic [CW-1:0]   count_d;

    // Credit covers queued plus in-flight entries, so a captured fetch always has a free slot
    always_comb begin
        credit      = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
        issue       = (state_q == RUN) && (credit < CSW'(DEPTH)) && !redirect;
        push        = inflight_q && !redirect;
        dec_valid_w = (count_q != '0) && !redirect;
        pop         = dec_valid_w && bus.dec_ready;
        count_d     = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    assign bus.imem_addr = pc_q;
    assign bus.dec_valid = dec_valid_w;
    assign bus.dec_instr = instr_mem_q[rd_ptr_q];
    assign bus.dec_pc    = pc_mem_q[rd_ptr_q];

    // Run/idle control: fetch_en alone moves the state, redirect never does
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE:    if (fetch_en)  state_q <= RUN;
                RUN:     if (!fetch_en) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // PC, in-flight tracking and queue bookkeeping; redirect flushes everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 8'h00;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else if (redirect) begin
            pc_q       <= redirect_pc;
            inflight_q <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                inflight_pc_q <= pc_q;
                pc_q          <= pc_q + 8'h01;
            end
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    // Queue storage: the instruction returned this cycle belongs to the previously issued PC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                instr_mem_q[i] <= 32'h0;
                pc_mem_q[i]    <= 8'h00;
            end
        end else if (push) begin
            instr_mem_q[wr_ptr_q] <= bus.imem_instr;
            pc_mem_q[wr_ptr_q]    <= inflight_pc_q;
        end
    end

`ifdef FETCH_STATS_EN
    logic [15:0] fetch_cnt_q;
    logic [15:0] flush_cnt_q;

    // Delivered-instruction and redirect counters, free-running with natural wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= 16'h0;
            flush_cnt_q <= 16'h0;
        end else begin
            if (pop)      fetch_cnt_q <= fetch_cnt_q + 16'h1;
            if (redirect) flush_cnt_q <= flush_cnt_q + 16'h1;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit
module tb_instr_fetch_unit;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       fetch_en = 1'b0;
    logic       redirect = 1'b0;
    logic [7:0] redirect_pc = 8'h00;
    int         checks = 0;
    int         errors = 0;
    int         ncyc;

    typedef struct {
        logic [7:0]  pc;
        logic [31:0] instr;
    } exp_t;
    exp_t sb[$];

    instr_fetch_unit_if bus();

`ifdef FETCH_STATS_EN
    logic [15:0] fetch_cnt;
    logic [15:0] flush_cnt;
`endif

    instr_fetch_unit #(.DEPTH(4), .RESET_PC(8'h00)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_en    (fetch_en),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .bus         (bus)
`ifdef FETCH_STATS_EN
        ,
        .fetch_cnt   (fetch_cnt),
        .flush_cnt   (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Instruction memory model: word A = A000_0000 + A, registered read
    always @(posedge clk) bus.imem_instr <= 32'hA000_0000 + {24'h0, bus.imem_addr};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every handshake is compared against the oldest expected entry
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.dec_valid && bus.dec_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: got pc %h, expected no handshake", bus.dec_pc);
            end else begin
                e = sb.pop_front();
                check("sb_pc", {24'h0, bus.dec_pc}, {24'h0, e.pc});
                check("sb_instr", bus.dec_instr, e.instr);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_seq(input logic [7:0] start, input int n);
        logic [7:0] p;
        for (int i = 0; i < n; i++) begin
            p = start + 8'(i);
            sb.push_back('{pc: p, instr: 32'hA000_0000 + {24'h0, p}});
        end
    endtask

    task automatic drain(output int n);
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        bus.dec_ready = 1'b0;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending entries, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        fetch_en = 1'b0;
        redirect = 1'b0;
        bus.dec_ready = 1'b0;
        #1;
        check("rst_imem_addr", {24'h0, bus.imem_addr}, 32'h0);
        check("rst_dec_valid", {31'h0, bus.dec_valid}, 32'h0);
        check("rst_dec_instr", bus.dec_instr, 32'h0);
        check("rst_dec_pc", {24'h0, bus.dec_pc}, 32'h0);
`ifdef FETCH_STATS_EN
        check("rst_fetch_cnt", {16'h0, fetch_cnt}, 32'h0);
        check("rst_flush_cnt", {16'h0, flush_cnt}, 32'h0);
`endif
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        bus.dec_ready = 1'b0;

        // 1: first-instruction latency then one per cycle
        do_reset();
        push_seq(8'h00, 8);
        fetch_en = 1'b1;
        bus.dec_ready = 1'b1;
        tick();
        check("lat_c1_valid", {31'h0, bus.dec_valid}, 32'h0);
        tick();
        check("lat_c2_valid", {31'h0, bus.dec_valid}, 32'h0);
        tick();
        check("lat_c3_valid", {31'h0, bus.dec_valid}, 32'h1);
        check("lat_c3_pc", {24'h0, bus.dec_pc}, 32'h0);
        drain(ncyc);

        // 2: back-pressure fills the queue, then back-to-back release
        do_reset();
        fetch_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.dec_valid) begin
                check("stall_head_instr", bus.dec_instr, 32'hA000_0000);
                check("stall_head_pc", {24'h0, bus.dec_pc}, 32'h0);
            end
        end
        check("full_imem_addr", {24'h0, bus.imem_addr}, 32'h4);
        check("full_dec_valid", {31'h0, bus.dec_valid}, 32'h1);
        push_seq(8'h00, 8);
        bus.dec_ready = 1'b1;
        drain(ncyc);
        check("b2b_cycles", ncyc, 32'd8);

        // 3: redirect with three queued entries
        do_reset();
        fetch_en = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("pre_redir_valid", {31'h0, bus.dec_valid}, 32'h1);
        redirect = 1'b1;
        redirect_pc = 8'h40;
        #1;
        check("redir_cycle_valid", {31'h0, bus.dec_valid}, 32'h0);
        tick();
        redirect = 1'b0;
        check("redir_next_valid", {31'h0, bus.dec_valid}, 32'h0);
        check("redir_imem_addr", {24'h0, bus.imem_addr}, 32'h40);
        tick();
        check("redir_c2_valid", {31'h0, bus.dec_valid}, 32'h0);
        tick();
        check("redir_c3_valid", {31'h0, bus.dec_valid}, 32'h1);
        check("redir_c3_pc", {24'h0, bus.dec_pc}, 32'h40);
        push_seq(8'h40, 3);
        bus.dec_ready = 1'b1;
        drain(ncyc);

        // 4: redirect near the top of the address space wraps
        push_seq(8'hFE, 4);
        redirect = 1'b1;
        redirect_pc = 8'hFE;
        bus.dec_ready = 1'b1;
        tick();
        redirect = 1'b0;
        check("wrap_imem_addr", {24'h0, bus.imem_addr}, 32'hFE);
        drain(ncyc);

        // 5: async reset mid-stream with a full queue
        for (int i = 0; i < 8; i++) tick();
        check("pre_rst_valid", {31'h0, bus.dec_valid}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'h0, bus.dec_valid}, 32'h0);
        check("mid_rst_imem_addr", {24'h0, bus.imem_addr}, 32'h0);
        tick();
        rst_n = 1'b1;
        check("post_rst_imem_addr", {24'h0, bus.imem_addr}, 32'h0);
        push_seq(8'h00, 4);
        bus.dec_ready = 1'b1;
        drain(ncyc);

`ifdef FETCH_STATS_EN
        // 6: statistics counters
        do_reset();
        push_seq(8'h00, 20);
        fetch_en = 1'b1;
        bus.dec_ready = 1'b1;
        drain(ncyc);
        redirect = 1'b1;
        redirect_pc = 8'h10;
        tick();
        redirect = 1'b0;
        tick();
        redirect = 1'b1;
        tick();
        redirect = 1'b0;
        tick();
        check("stat_fetch_cnt", {16'h0, fetch_cnt}, 32'd20);
        check("stat_flush_cnt", {16'h0, flush_cnt}, 32'd2);
`endif

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
